// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Purpose:
//   Central hazard sequencer for the five-stage RV32I pipeline. It produces
//   the execute-stage forwarding selects and the stall/flush enables for every
//   pipeline register. A small FSM freezes the whole pipeline while the data
//   memory is not ready; a wait that lasts too long latches a sticky fatal
//   error. A saturating counter records how many cycles fetch was stalled.
//
// Parameters:
//   DATA_WIDTH  width of StallCycles_o
//   MAX_WAIT    consecutive not-ready memory cycles before timeout (2..255)
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst_n          synchronous active-low reset
//   Rs1D_i/Rs2D_i  decode-stage source registers
//   Rs1E_i/Rs2E_i  execute-stage source registers
//   RdE_i          execute-stage destination register
//   ResultsSrcE_i  execute-stage result select (2'b01 = load)
//   PCSrcE_i       branch/jump taken, resolved in execute
//   RdM_i          memory-stage destination register
//   RegWriteM_i    memory-stage register write enable
//   MemReqM_i      memory stage performs a load/store this cycle
//   MemReady_i     data memory completes the access this cycle
//   RdW_i          writeback-stage destination register
//   RegWriteW_i    writeback-stage register write enable
//   ForwardAE_o    execute operand A select (00 regfile, 01 WB, 10 MEM)
//   ForwardBE_o    execute operand B select (00 regfile, 01 WB, 10 MEM)
//   StallF_o..StallM_o  hold PC / decode / execute / execute-to-memory reg
//   FlushD_o/FlushE_o/FlushW_o  bubble into decode / execute / writeback
//   MemTimeout_o   sticky memory timeout error
//   StallCycles_o  saturating count of cycles with StallF_o asserted
// -----------------------------------------------------------------------------
module pipeline_hazard_controller #(
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WAIT   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4:0]            Rs1D_i,
   input  logic [4:0]            Rs2D_i,
   input  logic [4:0]            Rs1E_i,
   input  logic [4:0]            Rs2E_i,
   input  logic [4:0]            RdE_i,
   input  logic [1:0]            ResultsSrcE_i,
   input  logic                  PCSrcE_i,
   input  logic [4:0]            RdM_i,
   input  logic                  RegWriteM_i,
   input  logic                  MemReqM_i,
   input  logic                  MemReady_i,
   input  logic [4:0]            RdW_i,
   input  logic                  RegWriteW_i,
   output logic [1:0]            ForwardAE_o,
   output logic [1:0]            ForwardBE_o,
   output logic                  StallF_o,
   output logic                  StallD_o,
   output logic                  StallE_o,
   output logic                  StallM_o,
   output logic                  FlushD_o,
   output logic                  FlushE_o,
   output logic                  FlushW_o,
   output logic                  MemTimeout_o,
   output logic [DATA_WIDTH-1:0] StallCycles_o
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_ERROR = 2'd2
   } state_t;

   // Last legal wait count; reaching it while still not ready is a timeout.
   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t                state_q;
   logic [7:0]            wait_cnt_q;
   logic                  timeout_q;
   logic [DATA_WIDTH-1:0] stall_cycles_q;
   logic [DATA_WIDTH-1:0] stall_cycles_d;

   logic                  mem_not_ready;
   logic                  mem_stall;
   logic                  load_use;

   // ------------------------------------------------------------------
   // Forwarding: one identical mux per execute operand. The memory stage
   // holds the younger result, so it wins over writeback.
   // ------------------------------------------------------------------
   logic [9:0] rs_e;
   logic [3:0] fwd_sel;

   assign rs_e = {Rs2E_i, Rs1E_i};

   for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic [4:0] rs;
      logic       hit_m;
      logic       hit_w;

      assign rs    = rs_e[gi*5 +: 5];
      assign hit_m = RegWriteM_i && (RdM_i != 5'd0) && (RdM_i == rs);
      assign hit_w = RegWriteW_i && (RdW_i != 5'd0) && (RdW_i == rs);

      assign fwd_sel[gi*2 +: 2] = !rst_n ? 2'b00 :
                                  hit_m  ? 2'b10 :
                                  hit_w  ? 2'b01 : 2'b00;
   end

   assign ForwardAE_o = fwd_sel[1:0];
   assign ForwardBE_o = fwd_sel[3:2];

   // ------------------------------------------------------------------
   // Hazard detection
   // ------------------------------------------------------------------
   assign mem_not_ready = MemReqM_i && !MemReady_i;
   // ERROR keeps the pipeline frozen regardless of the memory handshake.
   assign mem_stall     = mem_not_ready || (state_q == ST_ERROR);
   assign load_use      = (ResultsSrcE_i == 2'b01) && (RdE_i != 5'd0) &&
                          ((RdE_i == Rs1D_i) || (RdE_i == Rs2D_i));

   // ------------------------------------------------------------------
   // Stall / flush priority. A memory stall defers any branch flush or
   // load-use stall: the frozen pipeline keeps presenting those inputs, so
   // they are acted on once the access completes. A taken branch beats a
   // load-use because the dependent instruction is discarded anyway.
   // ------------------------------------------------------------------
   always_comb begin
      StallF_o = 1'b0;
      StallD_o = 1'b0;
      StallE_o = 1'b0;
      StallM_o = 1'b0;
      FlushD_o = 1'b0;
      FlushE_o = 1'b0;
      FlushW_o = 1'b0;
      if (!rst_n) begin
         FlushD_o = 1'b1;
         FlushE_o = 1'b1;
         FlushW_o = 1'b1;
      end else if (mem_stall) begin
         StallF_o = 1'b1;
         StallD_o = 1'b1;
         StallE_o = 1'b1;
         StallM_o = 1'b1;
         // Writeback would otherwise retire the stalled memory op repeatedly.
         FlushW_o = 1'b1;
      end else if (PCSrcE_i) begin
         FlushD_o = 1'b1;
         FlushE_o = 1'b1;
      end else if (load_use) begin
         StallF_o = 1'b1;
         StallD_o = 1'b1;
         FlushE_o = 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Memory-wait FSM. The RUN->WAIT cycle already counts as the first
   // not-ready cycle, so the counter is loaded with 1 on entry; a timeout
   // then fires after exactly MAX_WAIT consecutive not-ready cycles.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         wait_cnt_q <= 8'd0;
         timeout_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (mem_not_ready) begin
                  state_q    <= ST_WAIT;
                  wait_cnt_q <= 8'd1;
               end else begin
                  wait_cnt_q <= 8'd0;
               end
            end
            ST_WAIT: begin
               // Ready on the timeout cycle still completes the access.
               if (MemReady_i) begin
                  state_q    <= ST_RUN;
                  wait_cnt_q <= 8'd0;
               end else if (wait_cnt_q == WAIT_LAST) begin
                  state_q   <= ST_ERROR;
                  timeout_q <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 8'd1;
               end
            end
            ST_ERROR: begin
               // Absorbing; only reset leaves this state.
               state_q   <= ST_ERROR;
               timeout_q <= 1'b1;
            end
            default: begin
               state_q    <= ST_RUN;
               wait_cnt_q <= 8'd0;
            end
         endcase
      end
   end

   assign MemTimeout_o = timeout_q;

   // ------------------------------------------------------------------
   // Saturating stall-cycle counter
   // ------------------------------------------------------------------
   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (StallF_o && (stall_cycles_q != {DATA_WIDTH{1'b1}})) begin
         stall_cycles_d = stall_cycles_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cycles_q <= '0;
      end else begin
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign StallCycles_o = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

   localparam int DW = 4;
   localparam int MW = 4;

   // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
   localparam logic [6:0] CTL_NONE = 7'b0000000;
   localparam logic [6:0] CTL_RST  = 7'b0000111;
   localparam logic [6:0] CTL_MEM  = 7'b1111001;
   localparam logic [6:0] CTL_LU   = 7'b1100010;
   localparam logic [6:0] CTL_BR   = 7'b0000110;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic [1:0]    ResultsSrcE;
   logic          PCSrcE, RegWriteM, MemReqM, MemReady, RegWriteW;
   logic [1:0]    ForwardAE, ForwardBE;
   logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
   logic          MemTimeout;
   logic [DW-1:0] StallCycles;
   logic [6:0]    ctl;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [DW-1:0] exp_cnt;

   assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

   always #5 clk = ~clk;

   pipeline_hazard_controller #(.DATA_WIDTH(DW), .MAX_WAIT(MW)) dut (
      .clk(clk), .rst_n(rst_n),
      .Rs1D_i(Rs1D), .Rs2D_i(Rs2D), .Rs1E_i(Rs1E), .Rs2E_i(Rs2E), .RdE_i(RdE),
      .ResultsSrcE_i(ResultsSrcE), .PCSrcE_i(PCSrcE),
      .RdM_i(RdM), .RegWriteM_i(RegWriteM), .MemReqM_i(MemReqM), .MemReady_i(MemReady),
      .RdW_i(RdW), .RegWriteW_i(RegWriteW),
      .ForwardAE_o(ForwardAE), .ForwardBE_o(ForwardBE),
      .StallF_o(StallF), .StallD_o(StallD), .StallE_o(StallE), .StallM_o(StallM),
      .FlushD_o(FlushD), .FlushE_o(FlushE), .FlushW_o(FlushW),
      .MemTimeout_o(MemTimeout), .StallCycles_o(StallCycles)
   );

   // Drive every non-reset input to its quiet value.
   task automatic idle();
      Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0;
      RdM = 5'd0; RdW = 5'd0; ResultsSrcE = 2'b00; PCSrcE = 1'b0;
      RegWriteM = 1'b0; MemReqM = 1'b0; MemReady = 1'b0; RegWriteW = 1'b0;
   endtask

   // Advance one rising edge, return on the following falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle();
      RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5; Rs2E = 5'd5;
      PCSrcE = 1'b1; MemReqM = 1'b1;
      @(negedge clk);
      #1;
      n_cmp++;
      if (ctl !== CTL_RST) begin
         n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, CTL_RST);
      end
      n_cmp++;
      if ({ForwardAE, ForwardBE} !== 4'b0000) begin
         n_err++; $display("FAIL reset_fwd: got %b%b want 0000", ForwardAE, ForwardBE);
      end
      tick();
      n_cmp++;
      if (StallCycles !== 4'd0) begin
         n_err++; $display("FAIL reset_cnt: got %0d want 0", StallCycles);
      end
      n_cmp++;
      if (MemTimeout !== 1'b0) begin
         n_err++; $display("FAIL reset_timeout: got %b want 0", MemTimeout);
      end
      idle();
      rst_n = 1'b1;
      exp_cnt = 4'd0;
      $display("test_reset done");
   endtask

   task automatic test_forwarding();
      idle();
      RegWriteM = 1'b1; RdM = 5'd5; RegWriteW = 1'b1; RdW = 5'd5;
      Rs1E = 5'd5; Rs2E = 5'd5;
      #1;
      n_cmp++;
      if ({ForwardAE, ForwardBE} !== 4'b1010) begin
         n_err++; $display("FAIL fwd_mem_wins: got %b%b want 1010", ForwardAE, ForwardBE);
      end
      n_cmp++;
      if (ctl !== CTL_NONE) begin
         n_err++; $display("FAIL fwd_ctl: got %b want %b", ctl, CTL_NONE);
      end
      RdM = 5'd0;
      #1;
      n_cmp++;
      if ({ForwardAE, ForwardBE} !== 4'b0101) begin
         n_err++; $display("FAIL fwd_rdm_zero: got %b%b want 0101", ForwardAE, ForwardBE);
      end
      Rs1E = 5'd0;
      #1;
      n_cmp++;
      if ({ForwardAE, ForwardBE} !== 4'b0001) begin
         n_err++; $display("FAIL fwd_rs1_zero: got %b%b want 0001", ForwardAE, ForwardBE);
      end
      // Memory match blocked by write enable, operands on different regs.
      RdM = 5'd9; RegWriteM = 1'b0; RdW = 5'd9; Rs1E = 5'd9; Rs2E = 5'd3;
      #1;
      n_cmp++;
      if ({ForwardAE, ForwardBE} !== 4'b0100) begin
         n_err++; $display("FAIL fwd_wen_off: got %b%b want 0100", ForwardAE, ForwardBE);
      end
      RegWriteM = 1'b1; RdM = 5'd3;
      #1;
      n_cmp++;
      if ({ForwardAE, ForwardBE} !== 4'b0110) begin
         n_err++; $display("FAIL fwd_split: got %b%b want 0110", ForwardAE, ForwardBE);
      end
      tick();
      idle();
      $display("test_forwarding done");
   endtask

   task automatic test_load_use();
      idle();
      ResultsSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
      #1;
      n_cmp++;
      if (ctl !== CTL_LU) begin
         n_err++; $display("FAIL lu_ctl: got %b want %b", ctl, CTL_LU);
      end
      tick();
      exp_cnt = exp_cnt + 4'd1;
      n_cmp++;
      if (StallCycles !== exp_cnt) begin
         n_err++; $display("FAIL lu_cnt: got %0d want %0d", StallCycles, exp_cnt);
      end
      RdE = 5'd0; Rs2D = 5'd0;
      #1;
      n_cmp++;
      if (ctl !== CTL_NONE) begin
         n_err++; $display("FAIL lu_rd_zero: got %b want %b", ctl, CTL_NONE);
      end
      tick();
      n_cmp++;
      if (StallCycles !== exp_cnt) begin
         n_err++; $display("FAIL lu_cnt_hold: got %0d want %0d", StallCycles, exp_cnt);
      end
      RdE = 5'd12; Rs1D = 5'd12;
      #1;
      n_cmp++;
      if (ctl !== CTL_LU) begin
         n_err++; $display("FAIL lu_rs1: got %b want %b", ctl, CTL_LU);
      end
      tick();
      exp_cnt = exp_cnt + 4'd1;
      idle();
      $display("test_load_use done");
   endtask

   task automatic test_branch_load_use();
      idle();
      ResultsSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7; PCSrcE = 1'b1;
      #1;
      n_cmp++;
      if (ctl !== CTL_BR) begin
         n_err++; $display("FAIL br_over_lu: got %b want %b", ctl, CTL_BR);
      end
      tick();
      n_cmp++;
      if (StallCycles !== exp_cnt) begin
         n_err++; $display("FAIL br_cnt: got %0d want %0d", StallCycles, exp_cnt);
      end
      idle();
      $display("test_branch_load_use done");
   endtask

   task automatic test_mem_wait();
      idle();
      MemReqM = 1'b1;
      // Branch and load-use held during the stall must be deferred.
      PCSrcE = 1'b1; ResultsSrcE = 2'b01; RdE = 5'd4; Rs1D = 5'd4;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (ctl !== CTL_MEM) begin
            n_err++; $display("FAIL memwait_ctl[%0d]: got %b want %b", i, ctl, CTL_MEM);
         end
         tick();
         exp_cnt = exp_cnt + 4'd1;
      end
      MemReady = 1'b1;
      #1;
      n_cmp++;
      if (ctl !== CTL_BR) begin
         n_err++; $display("FAIL memwait_done_ctl: got %b want %b", ctl, CTL_BR);
      end
      tick();
      n_cmp++;
      if (StallCycles !== exp_cnt) begin
         n_err++; $display("FAIL memwait_cnt: got %0d want %0d", StallCycles, exp_cnt);
      end
      n_cmp++;
      if (MemTimeout !== 1'b0) begin
         n_err++; $display("FAIL memwait_timeout: got %b want 0", MemTimeout);
      end
      // Ready on the first cycle: no stall at all.
      idle();
      MemReqM = 1'b1; MemReady = 1'b1;
      #1;
      n_cmp++;
      if (ctl !== CTL_NONE) begin
         n_err++; $display("FAIL mem_first_ready: got %b want %b", ctl, CTL_NONE);
      end
      tick();
      idle();
      $display("test_mem_wait done");
   endtask

   task automatic test_timeout_ready_last();
      idle();
      MemReqM = 1'b1;
      for (int i = 0; i < MW - 1; i++) begin
         tick();
         exp_cnt = exp_cnt + 4'd1;
      end
      MemReady = 1'b1;
      tick();
      idle();
      #1;
      n_cmp++;
      if (MemTimeout !== 1'b0) begin
         n_err++; $display("FAIL ready_last_timeout: got %b want 0", MemTimeout);
      end
      n_cmp++;
      if (ctl !== CTL_NONE) begin
         n_err++; $display("FAIL ready_last_run: got %b want %b", ctl, CTL_NONE);
      end
      n_cmp++;
      if (StallCycles !== exp_cnt) begin
         n_err++; $display("FAIL ready_last_cnt: got %0d want %0d", StallCycles, exp_cnt);
      end
      $display("test_timeout_ready_last done");
   endtask

   task automatic test_timeout();
      idle();
      MemReqM = 1'b1;
      for (int i = 0; i < MW; i++) begin
         tick();
         exp_cnt = exp_cnt + 4'd1;
         n_cmp++;
         if (MemTimeout !== (i == MW - 1)) begin
            n_err++; $display("FAIL timeout_edge[%0d]: got %b want %b", i, MemTimeout, (i == MW - 1));
         end
      end
      // Frozen even after the request drops.
      idle();
      for (int i = 0; i < 3; i++) begin
         #1;
         n_cmp++;
         if (ctl !== CTL_MEM) begin
            n_err++; $display("FAIL error_frozen[%0d]: got %b want %b", i, ctl, CTL_MEM);
         end
         tick();
         exp_cnt = exp_cnt + 4'd1;
      end
      n_cmp++;
      if ({MemTimeout, StallCycles} !== {1'b1, exp_cnt}) begin
         n_err++; $display("FAIL error_state: got %b/%0d want 1/%0d", MemTimeout, StallCycles, exp_cnt);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_cnt = 4'd0;
      #1;
      n_cmp++;
      if ({MemTimeout, StallCycles} !== 5'd0) begin
         n_err++; $display("FAIL error_reset: got %b/%0d want 0/0", MemTimeout, StallCycles);
      end
      n_cmp++;
      if (ctl !== CTL_NONE) begin
         n_err++; $display("FAIL error_reset_run: got %b want %b", ctl, CTL_NONE);
      end
      $display("test_timeout done");
   endtask

   task automatic test_saturation();
      idle();
      ResultsSrcE = 2'b01; RdE = 5'd8; Rs2D = 5'd8;
      for (int i = 0; i < 15; i++) tick();
      n_cmp++;
      if (StallCycles !== 4'd15) begin
         n_err++; $display("FAIL sat_reach: got %0d want 15", StallCycles);
      end
      tick();
      tick();
      n_cmp++;
      if (StallCycles !== 4'd15) begin
         n_err++; $display("FAIL sat_hold: got %0d want 15", StallCycles);
      end
      idle();
      $display("test_saturation done");
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      exp_cnt = 4'd0;
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch_load_use();
      test_mem_wait();
      test_timeout_ready_last();
      test_timeout();
      test_saturation();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central sequencer for the five-stage pipelined RV32I core. Produces forwarding selects for the execute stage and stall/flush enables for every pipeline register, including the execute-to-memory register. Owns a small FSM that freezes the pipeline while the data memory is not ready, with a timeout that latches a fatal error. Also keeps a saturating stall-cycle counter for performance measurement.

## Interface
- `DATA_WIDTH`, 32: width of `StallCycles_o`.
- `MAX_WAIT`, 16: maximum consecutive memory-wait cycles before timeout; legal range 2..255.
- `clk` input 1: single clock; FSM and counters update on rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `Rs1D_i`, `Rs2D_i` input 5 each: source registers in decode.
- `Rs1E_i`, `Rs2E_i`, `RdE_i` input 5 each: sources and destination in execute.
- `ResultsSrcE_i` input 2: result select in execute; `2'b01` marks a load.
- `PCSrcE_i` input 1: branch/jump taken, resolved in execute.
- `RdM_i` input 5: destination in memory stage.
- `RegWriteM_i` input 1: register write enable in memory stage.
- `MemReqM_i` input 1: memory stage performs a load or store this cycle.
- `MemReady_i` input 1: data memory completes the access this cycle.
- `RdW_i` input 5: destination in writeback.
- `RegWriteW_i` input 1: register write enable in writeback.
- `ForwardAE_o`, `ForwardBE_o` output 2 each: `00` = register file, `01` = writeback result, `10` = memory-stage ALU result.
- `StallF_o`, `StallD_o`, `StallE_o`, `StallM_o` output 1 each: hold the PC / decode / execute / execute-to-memory register.
- `FlushD_o`, `FlushE_o`, `FlushW_o` output 1 each: load a bubble into decode / execute / writeback.
- `MemTimeout_o` output 1: sticky timeout error.
- `StallCycles_o` output `DATA_WIDTH`: saturating count of stalled cycles.

## Operation
- Forwarding (A; B identical with `Rs2E_i`): `10` if `RegWriteM_i && RdM_i!=0 && RdM_i==Rs1E_i`; else `01` if `RegWriteW_i && RdW_i!=0 && RdW_i==Rs1E_i`; else `00`. The memory stage wins when both match.
- LoadUse = `ResultsSrcE_i==2'b01 && RdE_i!=0 && (RdE_i==Rs1D_i || RdE_i==Rs2D_i)`.
- MemStall = `MemReqM_i && !MemReady_i`, or FSM in ERROR.
- FSM states:
  - RUN: go to WAIT if MemStall.
  - WAIT: go to RUN when `MemReady_i`; go to ERROR when `WaitCnt==MAX_WAIT-1` and `!MemReady_i`.
  - ERROR: absorbing; left only by reset.
- `WaitCnt` (8 bits):
  - Cleared in RUN.
  - Increments each WAIT cycle.
  - `MemReady_i` on the timeout cycle wins; the FSM returns to RUN.
- Output priority, highest first:
  1. MemStall: `StallF/D/E/M`=1, `FlushW`=1, `FlushD/E`=0. The branch flush and load-use are deferred; their inputs are held stable by the stall.
  2. `PCSrcE_i`: `FlushD`=1, `FlushE`=1, stalls 0. Overrides LoadUse, because the stalled instruction is being discarded.
  3. LoadUse: `StallF`=1, `StallD`=1, `FlushE`=1.
  4. Otherwise all stall and flush outputs are 0.
- `MemTimeout_o`: set on entry to ERROR; in ERROR all stalls and `FlushW` are held at 1.
- `StallCycles_o`: +1 on every cycle where `StallF_o`=1; saturates at all-ones, no wrap.

## Timing
- Forwarding, stall and flush outputs are combinational from inputs and current state, valid the same cycle.
- Pipeline registers sample them at their next active edge.
- FSM, `WaitCnt`, `MemTimeout_o` and `StallCycles_o` are registered, with one-cycle latency.
- Reset (`rst_n`=0 at a rising edge):
  - State RUN, `WaitCnt`=0, `MemTimeout_o`=0, `StallCycles_o`=0.
  - While `rst_n`=0: `FlushD/E/W`=1, all stalls 0, forwards `00`.
- Reset mid-WAIT or in ERROR returns to RUN on the next edge and discards the pending wait.
- A memory access that completes on its first cycle (`MemReady_i`=1) causes no stall and no state change.
- Minimum WAIT residency is one cycle.
- A timeout fires after exactly `MAX_WAIT` consecutive not-ready cycles, counting the RUN→WAIT cycle.

## Test plan
- Back-to-back ALU dependency: `RdM`=5 and `RdW`=5 both writing, `Rs1E`=5. Expect `ForwardAE`=`10`. With `RdM`=0, expect `01`. With `Rs1E`=0, expect `00`.
- Load-use: `ResultsSrcE`=`01`, `RdE`=7, `Rs2D`=7. Expect `StallF`=`StallD`=`FlushE`=1 for one cycle and `StallCycles` +1. With `RdE`=0, expect no stall.
- Branch plus load-use in the same cycle: `PCSrcE`=1 with a LoadUse match. Expect `FlushD`=`FlushE`=1, `StallF`=0.
- Memory wait: `MemReqM`=1, `MemReady` low for 3 cycles then high. Expect all four stalls and `FlushW` high for 3 cycles, `StallCycles`=3, FSM back in RUN, `MemTimeout`=0.
- Timeout: `MAX_WAIT`=4, `MemReady` held low. Expect `MemTimeout`=1 after the 4th cycle, pipeline frozen indefinitely; `rst_n` low for one edge clears it. A variant with `MemReady` high on the 4th cycle expects no timeout.
- Saturation: preload `StallCycles` near all-ones (`DATA_WIDTH`=4, 15 stalls), stall again. Expect it to stay at 15.
